// File: rtl/enc_seq_pkg.sv
// Shared types and constants for the encoder sequencer and its round-robin arbiter.
package enc_seq_pkg;
  localparam int NIB_W    = 4;
  localparam int DEF_NREQ = 2;
  localparam int ID_W     = $clog2(DEF_NREQ);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRIVE,
    WAIT,
    CAPTURE,
    DONE
  } state_e;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/encoder_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping; one-hot grant plus index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            req_any
);
  int j;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    req_any = 1'b0;
    j       = 0;
    for (int off = 0; off < NREQ; off++) begin
      j = (int'(ptr) + off) % NREQ;
      if (!req_any && req[j]) begin
        req_any = 1'b1;
        gnt[j]  = 1'b1;
        idx     = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/encoder_sequencer.sv
// Time-shares one nibble encoder among NREQ requesters; a word completes 2+DIGITS*(2+ENC_LAT)
// cycles after accept, and the response is held in DONE until rsp_ready (no new grant meanwhile).
module encoder_sequencer
  import enc_seq_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DIGITS  = 4,
  parameter int ENC_LAT = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ*DIGITS*NIB_W-1:0]    req_data,
  output logic [NREQ-1:0]                 req_ready,
  output logic                            rsp_valid,
  output logic [$clog2(NREQ)-1:0]         rsp_id,
  output logic [DIGITS*NIB_W-1:0]         rsp_data,
  input  logic                            rsp_ready,
  output logic                            busy,
  output logic                            enc_reset,
  output logic                            enc_ready,
  output logic [NIB_W-1:0]                enc_in,
  input  logic [NIB_W-1:0]                enc_out
);
  localparam int IDW    = $clog2(NREQ);
  localparam int DW     = DIGITS * NIB_W;
  localparam int DIG_W  = idx_w(DIGITS);
  localparam int WAIT_W = idx_w(ENC_LAT);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DW-1:0]      data_q, data_d;
  logic [DW-1:0]      result_q, result_d;
  logic [NIB_W-1:0]   enc_in_q, enc_in_d;
  logic               enc_reset_q, enc_reset_d;
  logic               enc_ready_q, enc_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;

  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               req_any;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .idx     (gnt_idx),
    .req_any (req_any)
  );

  // Accept is only possible from IDLE, so the strobe is the arbiter grant gated by state.
  assign req_ready = (state_q == IDLE) ? gnt : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = result_q;
  assign busy      = busy_q;
  assign enc_reset = enc_reset_q;
  assign enc_ready = enc_ready_q;
  assign enc_in    = enc_in_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    digit_d     = digit_q;
    wait_d      = wait_q;
    data_d      = data_q;
    result_d    = result_q;
    enc_in_d    = enc_in_q;
    enc_reset_d = 1'b0;
    enc_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    busy_d      = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req_any) begin
          state_d     = CLEAR;
          busy_d      = 1'b1;
          enc_reset_d = 1'b1;
          id_d        = gnt_idx;
          data_d      = req_data[int'(gnt_idx)*DW +: DW];
          ptr_d       = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
      end
      CLEAR: begin
        digit_d     = '0;
        enc_ready_d = 1'b1;
        enc_in_d    = data_q[DW-1 -: NIB_W];
        state_d     = DRIVE;
      end
      DRIVE: begin
        wait_d  = '0;
        state_d = (ENC_LAT == 0) ? CAPTURE : WAIT;
      end
      WAIT: begin
        if (int'(wait_q) >= ENC_LAT - 1) state_d = CAPTURE;
        else wait_d = wait_q + 1'b1;
      end
      CAPTURE: begin
        result_d = (result_q << NIB_W) | DW'(enc_out);
        if (int'(digit_q) == DIGITS - 1) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end else begin
          // Data register shifts left so the next nibble is always at the top.
          digit_d     = digit_q + 1'b1;
          data_d      = data_q << NIB_W;
          enc_in_d    = data_d[DW-1 -: NIB_W];
          enc_ready_d = 1'b1;
          state_d     = DRIVE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      digit_q     <= '0;
      wait_q      <= '0;
      data_q      <= '0;
      result_q    <= '0;
      enc_in_q    <= '0;
      enc_reset_q <= 1'b1;
      enc_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      digit_q     <= digit_d;
      wait_q      <= wait_d;
      data_q      <= data_d;
      result_q    <= result_d;
      enc_in_q    <= enc_in_d;
      enc_reset_q <= enc_reset_d;
      enc_ready_q <= enc_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end
endmodule
